// File: rtl/pulse_width_meter.sv
// Measures high- and low-phase durations from edge-detector pulses and reports
// each completed phase as a registered width with a one-cycle valid strobe.
module pulse_width_meter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pos_edge,
  input  logic             neg_edge,
  output logic [CNT_W-1:0] high_width,
  output logic             high_valid,
  output logic [CNT_W-1:0] low_width,
  output logic             low_valid,
  output logic             sat,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             cnt_sat_q;
  logic [CNT_W-1:0] high_width_q;
  logic [CNT_W-1:0] low_width_q;
  logic             high_valid_q;
  logic             low_valid_q;
  logic             sat_q;
  logic             err_q;

  // Saturating increment; the counter parks at its maximum value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    if (value == CNT_MAX) begin
      sat_inc = value;
    end else begin
      sat_inc = value + CNT_ONE;
    end
  endfunction

  // Phase-tracking FSM with phase counter and registered measurement outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= CNT_ZERO;
      cnt_sat_q    <= 1'b0;
      high_width_q <= CNT_ZERO;
      low_width_q  <= CNT_ZERO;
      high_valid_q <= 1'b0;
      low_valid_q  <= 1'b0;
      sat_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      high_valid_q <= 1'b0;
      low_valid_q  <= 1'b0;
      sat_q        <= 1'b0;
      err_q        <= 1'b0;
      if (pos_edge && neg_edge) begin
        // Direction is unknowable, so drop back and wait for a clean edge.
        err_q     <= 1'b1;
        state_q   <= IDLE;
        cnt_q     <= CNT_ZERO;
        cnt_sat_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (pos_edge) begin
              state_q   <= HIGH;
              cnt_q     <= CNT_ONE;
              cnt_sat_q <= 1'b0;
            end else if (neg_edge) begin
              state_q   <= LOW;
              cnt_q     <= CNT_ONE;
              cnt_sat_q <= 1'b0;
            end else begin
              state_q <= IDLE;
            end
          end
          HIGH: begin
            if (neg_edge) begin
              high_width_q <= cnt_q;
              high_valid_q <= 1'b1;
              sat_q        <= cnt_sat_q;
              cnt_q        <= CNT_ONE;
              cnt_sat_q    <= 1'b0;
              state_q      <= LOW;
            end else if (pos_edge) begin
              err_q     <= 1'b1;
              cnt_q     <= CNT_ONE;
              cnt_sat_q <= 1'b0;
            end else begin
              cnt_q <= sat_inc(cnt_q);
              if (cnt_q == CNT_MAX) begin
                cnt_sat_q <= 1'b1;
              end
            end
          end
          LOW: begin
            if (pos_edge) begin
              low_width_q <= cnt_q;
              low_valid_q <= 1'b1;
              sat_q       <= cnt_sat_q;
              cnt_q       <= CNT_ONE;
              cnt_sat_q   <= 1'b0;
              state_q     <= HIGH;
            end else if (neg_edge) begin
              err_q     <= 1'b1;
              cnt_q     <= CNT_ONE;
              cnt_sat_q <= 1'b0;
            end else begin
              cnt_q <= sat_inc(cnt_q);
              if (cnt_q == CNT_MAX) begin
                cnt_sat_q <= 1'b1;
              end
            end
          end
          default: begin
            state_q   <= IDLE;
            cnt_q     <= CNT_ZERO;
            cnt_sat_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign high_width = high_width_q;
  assign low_width  = low_width_q;
  assign high_valid = high_valid_q;
  assign low_valid  = low_valid_q;
  assign sat        = sat_q;
  assign err        = err_q;

endmodule

// File: tb/tb_pulse_width_meter.sv
// Directed bench for pulse_width_meter: a default-width instance plus a
// CNT_W=4 instance sharing the same inputs for saturation scenarios.
module tb_pulse_width_meter;

  logic        clk;
  logic        rst;
  logic        pos_edge;
  logic        neg_edge;
  logic [15:0] hw;
  logic [15:0] lw;
  logic        hv;
  logic        lv;
  logic        sat;
  logic        err;
  logic [3:0]  s_hw;
  logic [3:0]  s_lw;
  logic        s_hv;
  logic        s_lv;
  logic        s_sat;
  logic        s_err;

  int checks;
  int failures;

  pulse_width_meter #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .pos_edge(pos_edge), .neg_edge(neg_edge),
    .high_width(hw), .high_valid(hv), .low_width(lw), .low_valid(lv),
    .sat(sat), .err(err)
  );

  pulse_width_meter #(.CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .pos_edge(pos_edge), .neg_edge(neg_edge),
    .high_width(s_hw), .high_valid(s_hv), .low_width(s_lw), .low_valid(s_lv),
    .sat(s_sat), .err(s_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present inputs for one cycle, then sample just after the rising edge.
  task automatic tick(input logic p, input logic n);
    pos_edge = p;
    neg_edge = n;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      tick(c == 1, c == 2);
      checks++;
      if ({hv, lv, sat, err, hw, lw} !== 36'd0) begin
        failures++;
        $display("FAIL reset_during c=%0d got hv=%b lv=%b sat=%b err=%b hw=%0d lw=%0d exp all 0",
                 c, hv, lv, sat, err, hw, lw);
      end
    end
    rst = 1'b0;
    // A single edge after reset starts a phase but reports nothing.
    for (int c = 1; c <= 4; c++) begin
      tick(c == 2, 1'b0);
      checks++;
      if ({hv, lv, sat, err, hw, lw} !== 36'd0) begin
        failures++;
        $display("FAIL reset_after c=%0d got hv=%b lv=%b sat=%b err=%b hw=%0d lw=%0d exp all 0",
                 c, hv, lv, sat, err, hw, lw);
      end
    end
  endtask

  task automatic test_basic();
    logic [3:0]  ef;
    logic [15:0] ehw, elw;
    do_reset();
    for (int c = 1; c <= 14; c++) begin
      tick(c == 5 || c == 12, c == 9);
      ef  = {c == 9, c == 12, 1'b0, 1'b0};
      ehw = (c >= 9) ? 16'd4 : 16'd0;
      elw = (c >= 12) ? 16'd3 : 16'd0;
      checks++;
      if ({hv, lv, sat, err} !== ef) begin
        failures++;
        $display("FAIL basic_flags cycle=%0d got=%b exp=%b", c + 1, {hv, lv, sat, err}, ef);
      end
      checks++;
      if (hw !== ehw || lw !== elw) begin
        failures++;
        $display("FAIL basic_width cycle=%0d got hw=%0d lw=%0d exp hw=%0d lw=%0d",
                 c + 1, hw, lw, ehw, elw);
      end
    end
  endtask

  task automatic test_min_width();
    logic [3:0]  ef;
    logic [15:0] ehw, elw;
    do_reset();
    for (int c = 1; c <= 9; c++) begin
      tick(c == 5 || c == 7, c == 6);
      ef  = {c == 6, c == 7, 1'b0, 1'b0};
      ehw = (c >= 6) ? 16'd1 : 16'd0;
      elw = (c >= 7) ? 16'd1 : 16'd0;
      checks++;
      if ({hv, lv, sat, err} !== ef) begin
        failures++;
        $display("FAIL min_flags cycle=%0d got=%b exp=%b", c + 1, {hv, lv, sat, err}, ef);
      end
      checks++;
      if (hw !== ehw || lw !== elw) begin
        failures++;
        $display("FAIL min_width cycle=%0d got hw=%0d lw=%0d exp hw=%0d lw=%0d",
                 c + 1, hw, lw, ehw, elw);
      end
    end
  endtask

  task automatic test_saturation();
    logic [3:0]  ef_s, ef_b;
    logic [3:0]  es_hw, es_lw;
    logic [15:0] eb_hw, eb_lw;
    do_reset();
    for (int c = 1; c <= 45; c++) begin
      tick(c == 2 || c == 40, c == 30);
      ef_s  = {c == 30, c == 40, c == 30, 1'b0};
      ef_b  = {c == 30, c == 40, 1'b0, 1'b0};
      es_hw = (c >= 30) ? 4'd15 : 4'd0;
      es_lw = (c >= 40) ? 4'd10 : 4'd0;
      eb_hw = (c >= 30) ? 16'd28 : 16'd0;
      eb_lw = (c >= 40) ? 16'd10 : 16'd0;
      checks++;
      if ({s_hv, s_lv, s_sat, s_err} !== ef_s) begin
        failures++;
        $display("FAIL sat_small_flags cycle=%0d got=%b exp=%b", c + 1, {s_hv, s_lv, s_sat, s_err}, ef_s);
      end
      checks++;
      if (s_hw !== es_hw || s_lw !== es_lw) begin
        failures++;
        $display("FAIL sat_small_width cycle=%0d got hw=%0d lw=%0d exp hw=%0d lw=%0d",
                 c + 1, s_hw, s_lw, es_hw, es_lw);
      end
      checks++;
      if ({hv, lv, sat, err} !== ef_b || hw !== eb_hw || lw !== eb_lw) begin
        failures++;
        $display("FAIL sat_wide cycle=%0d got flags=%b hw=%0d lw=%0d exp flags=%b hw=%0d lw=%0d",
                 c + 1, {hv, lv, sat, err}, hw, lw, ef_b, eb_hw, eb_lw);
      end
    end
  endtask

  task automatic test_illegal_repeat();
    logic [3:0]  ef;
    logic [15:0] ehw;
    do_reset();
    for (int c = 1; c <= 12; c++) begin
      tick(c == 5 || c == 8, c == 10);
      ef  = {c == 10, 1'b0, 1'b0, c == 8};
      ehw = (c >= 10) ? 16'd2 : 16'd0;
      checks++;
      if ({hv, lv, sat, err} !== ef || hw !== ehw || lw !== 16'd0) begin
        failures++;
        $display("FAIL repeat_edge cycle=%0d got flags=%b hw=%0d lw=%0d exp flags=%b hw=%0d lw=0",
                 c + 1, {hv, lv, sat, err}, hw, lw, ef, ehw);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0]  ef;
    logic [15:0] ehw;
    do_reset();
    for (int c = 1; c <= 13; c++) begin
      tick(c == 2 || c == 6 || c == 8, c == 4 || c == 6 || c == 11);
      ef  = {c == 4 || c == 11, 1'b0, 1'b0, c == 6};
      ehw = (c >= 11) ? 16'd3 : ((c >= 4) ? 16'd2 : 16'd0);
      checks++;
      if ({hv, lv, sat, err} !== ef || hw !== ehw || lw !== 16'd0) begin
        failures++;
        $display("FAIL simultaneous cycle=%0d got flags=%b hw=%0d lw=%0d exp flags=%b hw=%0d lw=0",
                 c + 1, {hv, lv, sat, err}, hw, lw, ef, ehw);
      end
    end
  endtask

  task automatic test_reset_mid_phase();
    logic [3:0]  ef;
    logic [15:0] elw;
    do_reset();
    for (int c = 1; c <= 17; c++) begin
      rst = (c == 8);
      tick(c == 5 || c == 15, c == 8 || c == 12);
      ef  = {1'b0, c == 15, 1'b0, 1'b0};
      elw = (c >= 15) ? 16'd3 : 16'd0;
      checks++;
      if ({hv, lv, sat, err} !== ef || hw !== 16'd0 || lw !== elw) begin
        failures++;
        $display("FAIL reset_mid cycle=%0d got flags=%b hw=%0d lw=%0d exp flags=%b hw=0 lw=%0d",
                 c + 1, {hv, lv, sat, err}, hw, lw, ef, elw);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ef;
    logic [15:0] ehw, elw;
    do_reset();
    for (int c = 1; c <= 11; c++) begin
      tick(c == 2 || c == 4 || c == 9, c == 3 || c == 5 || c == 6);
      ef  = {c == 3 || c == 5, c == 4 || c == 9, 1'b0, c == 6};
      ehw = (c >= 3) ? 16'd1 : 16'd0;
      elw = (c >= 9) ? 16'd3 : ((c >= 4) ? 16'd1 : 16'd0);
      checks++;
      if ({hv, lv, sat, err} !== ef || hw !== ehw || lw !== elw) begin
        failures++;
        $display("FAIL back_to_back cycle=%0d got flags=%b hw=%0d lw=%0d exp flags=%b hw=%0d lw=%0d",
                 c + 1, {hv, lv, sat, err}, hw, lw, ef, ehw, elw);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    pos_edge = 1'b0;
    neg_edge = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_min_width();
    test_saturation();
    test_illegal_repeat();
    test_simultaneous();
    test_reset_mid_phase();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
